mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences and shares the LC-3b memory unit between two requesters: instruction
//  fetch (F, word reads only) and data load/store (D, byte or word). Drives the
//  memory's MAR/MDR load strobes, datasize and rw, waits for the memory-ready flag,
//  then returns a one-cycle ack (or err) with read data. Sits between control/datapath and memory.
// PARAMETERS
//  TIMEOUT  31  max cycles in WAIT without mem_r before the access is aborted with err
// PORTS
//  clk_50       in   1   system clock; all logic on posedge
//  reset        in   1   synchronous, active-high reset
//  f_req        in   1   fetch request; held with f_addr stable until f_ack/f_err
//  f_addr       in   16  fetch word address
//  f_rdata      out  16  fetch read data, valid in the f_ack cycle
//  f_ack        out  1   one-cycle fetch completion
//  f_err        out  1   one-cycle fetch error (misaligned or timeout)
//  d_req        in   1   data request; d_we/d_size/d_addr/d_wdata held stable until d_ack/d_err
//  d_we         in   1   1 = store, 0 = load
//  d_size       in   1   1 = byte, 0 = word
//  d_addr       in   16  data address
//  d_wdata      in   16  store data (byte store uses [7:0])
//  d_rdata      out  16  load data, valid in the d_ack cycle
//  d_ack        out  1   one-cycle data completion
//  d_err        out  1   one-cycle data error
//  mem_addr     out  16  address to memory bus while mem_ld_mar high
//  mem_wdata    out  16  store data to memory bus while mem_ld_mdr high
//  mem_ld_mar   out  1   one-cycle MAR load strobe
//  mem_ld_mdr   out  1   one-cycle MDR load strobe
//  mem_datasize out  1   1 = byte; held for the whole access
//  mem_rw       out  1   1 = write; held for the whole access
//  mem_rdata    in   16  memory MDR contents
//  mem_r        in   1   memory-ready
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, last_grant=F, timeout counter 0.
//  States: IDLE, MAR, MDR, WAIT, DONE.
//  IDLE: if a req is high, grant. Only one high -> grant it. Both high -> grant D
//   unless last_grant==D, then F (alternation; first contention after reset goes to D).
//   Grant latches requester id, addr, we, size, wdata; last_grant updated.
//   Misaligned (word access with addr[0]=1; all fetches are word): no memory cycle;
//   next cycle the granted err pulses for 1 cycle, state -> IDLE.
//   Else -> MAR.
//  MAR (1 cycle): mem_ld_mar=1, mem_addr=latched addr. Write -> MDR; read -> WAIT.
//  MDR (1 cycle): mem_ld_mdr=1, mem_wdata=latched wdata -> WAIT.
//  WAIT: counter increments each cycle; mem_r=1 -> capture mem_rdata, -> DONE.
//   Counter reaching TIMEOUT without mem_r -> granted err pulses next cycle, -> IDLE.
//  DONE (1 cycle): granted ack=1, granted rdata = captured data (reads; 0 on writes)
//   -> IDLE. rdata holds its value until the next ack of that port.
//  Byte load: captured value passed through unmodified (memory already sign-extends).
//  ack and err never both high; never high on the non-granted port.
//  Requests are sampled only in IDLE; a req dropped mid-access still completes
//   the memory cycle, and its ack/err still pulses.
//  Minimum latency req->ack: read 3 cycles + memory wait; write 4 + memory wait.
//  IDLE always occupies >=1 cycle between accesses (no back-to-back grant from DONE).
//  Reset mid-access: immediate return to IDLE, strobes low, no ack/err; abandoned
//   access must be reissued by the requester.
// TESTING
//  1 f_req, f_addr=0x0010, mem_r 6 cycles after ld_mar, mem_rdata=0x1234 -> one mem_ld_mar with mem_addr=0x0010, f_ack 1 cycle, f_rdata=0x1234.
//  2 D word store addr 0x0020 data 0x00A7 -> ld_mar then ld_mdr next cycle, mem_rw=1, mem_datasize=0, mem_wdata=0x00A7, d_ack after mem_r.
//  3 f_req and d_req held high together for 3 accesses -> grant order D, F, D; exactly one ack per access.
//  4 D word load addr 0x0021 -> no ld_mar; d_err pulses 1 cycle, busy low after.
//  5 D byte load, mem_r never asserted -> d_err exactly TIMEOUT+1 cycles after WAIT entry, state IDLE.
//  6 reset asserted in WAIT -> next cycle all outputs 0, no ack; following f_req served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the LC-3b memory unit between instruction fetch (F) and data load/store (D).
// It sequences the MAR/MDR strobes and waits for mem_r, then returns a single-cycle ack or err.
module mem_arbiter #(
  parameter int TIMEOUT = 31
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic [15:0] f_rdata,
  output logic        f_ack,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_size,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_ld_mar,
  output logic        mem_ld_mdr,
  output logic        mem_datasize,
  output logic        mem_rw,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, MAR, MDR, WAIT, DONE, ERR} state_t;
  state_t state, state_nxt;

  logic          gnt_any, gnt_d_now, misalign;
  logic [15:0]   sel_addr;
  logic          gnt_d, last_d, we_q, size_q;
  logic [15:0]   addr_q, wdata_q, f_rdata_q, d_rdata_q;
  logic [CW-1:0] cnt;

  // Under contention D wins unless it won last time; fetches are always word-sized.
  always_comb begin
    gnt_any   = f_req | d_req;
    gnt_d_now = d_req & (~f_req | ~last_d);
    sel_addr  = gnt_d_now ? d_addr : f_addr;
    misalign  = ~(gnt_d_now & d_size) & sel_addr[0];
  end

  always_ff @(posedge clk_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_any) state_nxt = misalign ? ERR : MAR;
      MAR:  state_nxt = we_q ? MDR : WAIT;
      MDR:  state_nxt = WAIT;
      WAIT: begin
        if (mem_r)               state_nxt = DONE;
        else if (cnt == CNT_MAX) state_nxt = ERR;
      end
      DONE: state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      last_d    <= 1'b0;
      gnt_d     <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= 1'b0;
      cnt       <= '0;
      f_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      if (state == IDLE && gnt_any) begin
        gnt_d  <= gnt_d_now;
        last_d <= gnt_d_now;
        we_q   <= gnt_d_now & d_we;
        size_q <= gnt_d_now & d_size;
      end
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      // Read data lands in the port register as DONE is entered; stores return zero.
      if (state == WAIT && mem_r) begin
        if (gnt_d) d_rdata_q <= we_q ? 16'h0000 : mem_rdata;
        else       f_rdata_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (state == IDLE && gnt_any) begin
      addr_q  <= sel_addr;
      wdata_q <= d_wdata;
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    mem_ld_mar   = (state == MAR);
    mem_ld_mdr   = (state == MDR);
    mem_addr     = (state == MAR) ? addr_q : 16'h0000;
    mem_wdata    = (state == MDR) ? wdata_q : 16'h0000;
    mem_rw       = 1'b0;
    mem_datasize = 1'b0;
    if (state == MAR || state == MDR || state == WAIT || state == DONE) begin
      mem_rw       = we_q;
      mem_datasize = size_q;
    end
    f_ack = (state == DONE) & ~gnt_d;
    d_ack = (state == DONE) &  gnt_d;
    f_err = (state == ERR)  & ~gnt_d;
    d_err = (state == ERR)  &  gnt_d;
  end

  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized accesses.
// Each access is checked against a transaction-level model of grant order, latency and read data.
module tb_mem_arbiter;
  localparam int TIMEOUT = 31;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        f_req, f_ack, f_err;
  logic [15:0] f_addr, f_rdata;
  logic        d_req, d_we, d_size, d_ack, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ld_mar, mem_ld_mdr, mem_datasize, mem_rw, mem_r, busy;

  int total = 0;
  int bad = 0;

  // Model state: who won the last grant, and what each port's rdata should be holding.
  bit          m_last_d;
  logic [15:0] m_f_rdata, m_d_rdata;

  always #10 clk_50 = ~clk_50;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_50(clk_50), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ld_mar(mem_ld_mar),
    .mem_ld_mdr(mem_ld_mdr), .mem_datasize(mem_datasize), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .mem_r(mem_r), .busy(busy)
  );

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; mem_r = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_last_d = 1'b0; m_f_rdata = 16'h0000; m_d_rdata = 16'h0000;
  endtask

  // One access. mem_r pulses for one cycle, gap cycles after the observed MAR strobe.
  task automatic access(input bit f_on, input bit d_on, input logic [15:0] fa,
                        input bit dwe, input bit dsz, input logic [15:0] da,
                        input logic [15:0] dw, input logic [15:0] rd, input int gap,
                        output bit got_d);
    bit g_d, we, sz, mis, exp_err, done, p_ack, p_err;
    logic [15:0] a;
    int wentry, done_exp, n, mar_cyc, mar_cnt, mdr_cnt;
    g_d = d_on && (!f_on || !m_last_d);
    m_last_d = g_d;
    a   = g_d ? da : fa;
    we  = g_d && dwe;
    sz  = g_d && dsz;
    mis = !sz && a[0];
    wentry = we ? 3 : 2;
    exp_err = mis || (1 + gap > wentry + TIMEOUT);
    if (mis)          done_exp = 1;
    else if (exp_err) done_exp = wentry + TIMEOUT + 1;
    else              done_exp = gap + 2;
    f_req = f_on; f_addr = fa;
    d_req = d_on; d_we = dwe; d_size = dsz; d_addr = da; d_wdata = dw;
    mem_rdata = rd;
    mar_cyc = 0; mar_cnt = 0; mdr_cnt = 0; done = 1'b0; n = 0;
    while (!done && n < 80) begin
      tick(); n++;
      if (mem_ld_mar) begin
        mar_cnt++; mar_cyc = n;
        chk16("mem_addr", mem_addr, a);
      end
      if (mem_ld_mdr) begin
        mdr_cnt++;
        chk16("mem_wdata", mem_wdata, dw);
        chki("mdr_after_mar", n, mar_cyc + 1);
      end
      chk1("busy_during", busy, 1'b1);
      if (g_d) chk1("f_quiet", f_ack | f_err, 1'b0);
      else     chk1("d_quiet", d_ack | d_err, 1'b0);
      p_ack = g_d ? d_ack : f_ack;
      p_err = g_d ? d_err : f_err;
      if (p_ack | p_err) begin
        done = 1'b1;
        mem_r = 1'b0;
        chki("done_cycle", n, done_exp);
        chk1("err_pulse", p_err, exp_err);
        chk1("ack_pulse", p_ack, !exp_err);
        if (!exp_err) begin
          if (g_d) m_d_rdata = we ? 16'h0000 : rd;
          else     m_f_rdata = rd;
        end
        chk16("f_rdata", f_rdata, m_f_rdata);
        chk16("d_rdata", d_rdata, m_d_rdata);
        if (g_d) d_req = 1'b0;
        else     f_req = 1'b0;
      end else begin
        chk1("mem_rw", mem_rw, we);
        chk1("mem_datasize", mem_datasize, sz);
        mem_r = (mar_cyc > 0 && n == mar_cyc + gap);
      end
    end
    mem_r = 1'b0;
    chk1("done_seen", done, 1'b1);
    chki("mar_count", mar_cnt, mis ? 0 : 1);
    chki("mdr_count", mdr_cnt, (we && !mis) ? 1 : 0);
    tick();
    chk1("busy_after", busy, 1'b0);
    chk1("no_pulse_after", f_ack | f_err | d_ack | d_err, 1'b0);
    chk16("f_rdata_hold", f_rdata, m_f_rdata);
    chk16("d_rdata_hold", d_rdata, m_d_rdata);
    f_req = 1'b0; d_req = 1'b0;
    got_d = g_d;
  endtask

  initial begin
    bit g;
    bit fo, dn;
    int gap;
    logic [15:0] fa, da;
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 1'b0;
    f_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
    mem_rdata = 16'h0000; mem_r = 1'b0;
    do_reset();

    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_strobes", mem_ld_mar | mem_ld_mdr | mem_rw | mem_datasize, 1'b0);
    chk1("rst_pulses", f_ack | f_err | d_ack | d_err, 1'b0);
    chk16("rst_f_rdata", f_rdata, 16'h0000);
    chk16("rst_d_rdata", d_rdata, 16'h0000);
    chk16("rst_mem_addr", mem_addr, 16'h0000);

    // Contention right after reset: D, F, D.
    access(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hAAAA, 2, g);
    chk1("grant_1_is_d", g, 1'b1);
    access(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBBBB, 3, g);
    chk1("grant_2_is_d", g, 1'b0);
    access(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hCCCC, 2, g);
    chk1("grant_3_is_d", g, 1'b1);

    // Fetch, memory ready 6 cycles after MAR.
    access(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 6, g);
    chk16("fetch_rdata", f_rdata, 16'h1234);

    // Word store.
    access(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h00A7, 16'h5555, 3, g);
    chk16("store_rdata", d_rdata, 16'h0000);

    // Misaligned word load.
    access(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h7777, 2, g);

    // Byte load that times out.
    access(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0031, 16'h0000, 16'h0FF0, 1000, g);

    // Reset in the middle of a fetch's WAIT phase.
    f_req = 1'b1; f_addr = 16'h0040;
    tick(); tick(); tick();
    chk1("pre_reset_busy", busy, 1'b1);
    reset = 1'b1; f_req = 1'b0;
    tick();
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_strobes", mem_ld_mar | mem_ld_mdr | mem_rw | mem_datasize, 1'b0);
    chk1("midrst_pulses", f_ack | f_err | d_ack | d_err, 1'b0);
    chk16("midrst_f_rdata", f_rdata, 16'h0000);
    reset = 1'b0;
    m_last_d = 1'b0; m_f_rdata = 16'h0000; m_d_rdata = 16'h0000;
    mem_r = 1'b1;
    tick();
    mem_r = 1'b0;
    chk1("postrst_pulses", f_ack | f_err | d_ack | d_err, 1'b0);
    chk1("postrst_busy", busy, 1'b0);
    access(1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4321, 2, g);
    chk16("reissue_rdata", f_rdata, 16'h4321);

    // Randomized mix of requesters, sizes, alignments and memory delays.
    for (int i = 0; i < 24; i++) begin
      fo = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      if (!fo && !dn) dn = 1'b1;
      fa = 16'($urandom);
      da = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        fa[0] = 1'b0;
        da[0] = 1'b0;
      end
      gap = ($urandom_range(0, 7) == 0) ? 60 : int'($urandom_range(2, 9));
      access(fo, dn, fa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da,
             16'($urandom), 16'($urandom), gap, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
